// File: rtl/serializer_arbiter_pkg.sv
// Shared definitions for the serializer_arbiter slice.
// Provides default word/beat widths, derivation helpers for the beat count,
// source tag width and beat counter width, and the controller state enum.
package serializer_pkg;

  localparam int unsigned IN_WIDTH_DEF  = 64;
  localparam int unsigned OUT_WIDTH_DEF = 8;

  // Beats needed to emit one input word.
  function automatic int unsigned f_beats(input int unsigned in_w, input int unsigned out_w);
    return in_w / out_w;
  endfunction

  // Source tag width: max(1, clog2(n)).
  function automatic int unsigned f_src_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Beat counter width, never narrower than one bit.
  function automatic int unsigned f_cnt_w(input int unsigned beats);
    return (beats <= 2) ? 1 : $clog2(beats);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/serializer_arbiter_if.sv
// Handshake bundle between the requesters, the serializer and the egress link.
// Signals:
//   req_valid/req_data/req_ready : per-requester word handshake
//   out_valid/out_data/out_last/out_src/out_ready : byte-wide egress beats
//   busy : serializer is emitting a word
// master : producer/egress side (drives requests and out_ready)
// slave  : serializer side
interface serializer_arbiter_if
  import serializer_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
);
  localparam int unsigned SRC_W = f_src_w(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*IN_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        out_valid;
  logic [OUT_WIDTH-1:0]        out_data;
  logic                        out_last;
  logic [SRC_W-1:0]            out_src;
  logic                        out_ready;
  logic                        busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, busy
  );

endinterface

// File: rtl/serializer_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req   : request vector
//   i_ptr   : highest-priority index for this decision
//   i_en    : grant enable; no grant when low
//   o_grant : one-hot grant
//   o_idx   : encoded index of the granted requester
module rr_arbiter
  import serializer_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned SRC_W  = f_src_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [SRC_W-1:0]   o_idx
);

  int unsigned w_ptr;
  int unsigned w_dist;
  int unsigned w_best;
  int unsigned w_win;

  // The winner is the set request with the smallest upward distance from
  // i_ptr, modulo NUM_REQ.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_ptr   = 32'(i_ptr);
    w_dist  = 0;
    w_best  = NUM_REQ;
    w_win   = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      w_dist = (j + NUM_REQ - w_ptr) % NUM_REQ;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = j;
      end
    end
    if (i_en && (w_best < NUM_REQ)) begin
      o_grant[w_win] = 1'b1;
      o_idx          = w_win[SRC_W-1:0];
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// Round-robin arbitrated 64-to-8 serializer.
// Captures one requester's word per grant and emits it LSB byte first with a
// valid/ready handshake and the owning requester's index on out_src.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serializer_arbiter_if.slave handshake bundle
module serializer_arbiter
  import serializer_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serializer_arbiter_if.slave  bus
);

  localparam int unsigned BEATS = f_beats(IN_WIDTH, OUT_WIDTH);
  localparam int unsigned SRC_W = f_src_w(NUM_REQ);
  localparam int unsigned CNT_W = f_cnt_w(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [SRC_W-1:0] LAST_REQ  = SRC_W'(NUM_REQ - 1);

  state_t              r_state, w_state_nxt;
  logic [SRC_W-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]    r_beat_cnt, w_beat_cnt_nxt;
  logic [IN_WIDTH-1:0] r_word, w_word_nxt;
  logic [SRC_W-1:0]    r_src, w_src_nxt;

  logic [NUM_REQ-1:0]  w_grant;
  logic [SRC_W-1:0]    w_idx;
  logic                w_arb_en;
  logic                w_send;

  // Gating with rst_n keeps req_ready low while reset is held, even though
  // the arbiter itself is purely combinational.
  assign w_arb_en = (r_state == IDLE) && rst_n;
  assign w_send   = (r_state == SEND);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_word     <= '0;
      r_src      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_word     <= w_word_nxt;
      r_src      <= w_src_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_word_nxt     = r_word;
    w_src_nxt      = r_src;
    unique case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_word_nxt     = bus.req_data[w_idx*IN_WIDTH +: IN_WIDTH];
          w_src_nxt      = w_idx;
          w_beat_cnt_nxt = '0;
          w_rr_ptr_nxt   = (w_idx == LAST_REQ) ? '0 : w_idx + 1'b1;
          w_state_nxt    = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (r_beat_cnt == LAST_BEAT) begin
            w_beat_cnt_nxt = '0;
            w_state_nxt    = IDLE;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = w_grant;
    bus.out_valid = w_send;
    bus.busy      = w_send;
    bus.out_data  = w_send ? r_word[r_beat_cnt*OUT_WIDTH +: OUT_WIDTH] : '0;
    bus.out_last  = w_send && (r_beat_cnt == LAST_BEAT);
    bus.out_src   = w_send ? r_src : '0;
  end

endmodule
